bcd_time_counter: RTL and testbench
===================================

# bcd_time_counter

Time-of-day source for the clock datapath: keeps hours, minutes and seconds as packed BCD and advances them once per second, derived from the system clock by an internal prescaler. Its outputs drive the hourly chime logic and the display path unchanged. The block also takes a direct time load and a button-driven set mode, and emits pulses on every second, hour and day rollover.

## Interface
- DIV, default 1000: number of `cp` cycles per second. Legal range 2..65535. Benches use DIV=4.
- cp  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  one-cycle strobe; loads `ld_h`/`ld_m`/`ld_s` if they are valid.
- ld_h, ld_m, ld_s  in  8 each  BCD time to load: [7:4] tens digit, [3:0] units digit.
- set_en  in  1  level; high selects set mode.
- adj_sel  in  2  field to adjust: 00 seconds, 01 minutes, 10 hours, 11 none.
- adj_inc  in  1  one-cycle strobe; increments the selected field by one (set mode only).
- hours  out  8  BCD 00..23.
- minte  out  8  BCD 00..59.
- secd  out  8  BCD 00..59.
- sec_pulse  out  1  one cycle each time a run-mode second advance lands.
- hour_pulse  out  1  one cycle when a run-mode advance lands on xx:00:00.
- day_pulse  out  1  one cycle when a run-mode advance lands on 00:00:00.
- load_err  out  1  one cycle when a `load` is rejected.

## Operation
- State machine has two states, RUN and SET.
  - RUN→SET on the edge that samples `set_en`=1.
  - SET→RUN on the edge that samples `set_en`=0.
  - Leaving SET always clears the prescaler to 0, so the first second after setting is a full DIV cycles.
- Prescaler `pc`, 16 bits:
  - RUN: counts 0..DIV-1, then wraps to 0.
  - SET: held at 0.
  - A tick is asserted when `pc`==DIV-1 in RUN.
- Advance on tick, seconds→minutes→hours with ripple carry:
  - Units digit 9→0 increments the tens digit.
  - secd and minte: 59→00 carries into the next field.
  - hours: 23→00.
  - Digit arithmetic is 4-bit BCD only; binary values never appear on the outputs.
- Adjust (SET only): `adj_inc` increments the field chosen by `adj_sel`.
  - Same per-field wrap as the advance (59→00, 23→00), but with no carry into other fields.
  - No pulses are generated by an adjust.
  - `adj_sel`=11 does nothing.
  - `adj_inc` in RUN is ignored.
- Load, valid in either state. The load is rejected if any of the following holds:
  - any digit >9;
  - hours >23;
  - minte or secd >59.
  - Valid load: all three fields are written on the sampling edge and `pc` is cleared to 0.
  - Rejected load: `load_err`=1 for one cycle; fields and `pc` are unchanged.
- Same-cycle priority: load > adjust > tick.
  - A tick that coincides with a valid load is discarded.
  - A tick that coincides with a rejected load still advances the time.
- Pulses are asserted only for tick advances, never for load or adjust.
  - `day_pulse` implies `hour_pulse`, which implies `sec_pulse`, all in the same cycle.

## Timing
- Reset values: hours=8'h00, minte=8'h00, secd=8'h00; all pulses 0; `load_err`=0; state RUN; `pc`=0.
- Reset mid-count or mid-set takes effect immediately and asynchronously, giving the values above.
- After release, the first tick is when `pc` reaches DIV-1 (the DIV-th cycle); the new `secd` is visible after that edge.
- Outputs are registered. A field update and its pulse appear together, on the edge following the cycle where the tick is asserted.
- Steady state: exactly one advance per DIV cycles. `sec_pulse` is high for one cycle in every DIV.
- Load and adjust take effect one edge after the strobe is sampled. `load_err` is high for the cycle after the edge that sampled `load`.
- A held `adj_inc` increments on every cycle it is high; debouncing and edge detection are the caller's responsibility.

## Test plan
- Reset, DIV=4, run 12 cycles → secd steps 00→01→02→03 on cycles 4/8/12; `sec_pulse` high for exactly 3 single cycles; hour_pulse=0.
- Load 00:00:58, run 8 cycles → 00:00:59, then 00:01:00; `sec_pulse` for each step; no `hour_pulse`.
- Load 23:59:59, run 4 cycles → 00:00:00; `sec_pulse`, `hour_pulse` and `day_pulse` all high in the same single cycle.
- Load 24:00:00, then 12:5A:00 → `load_err` pulses for each; time and `pc` unchanged; counting continues; an aligned tick still advances.
- `set_en`=1; `adj_sel`=10 with 3 `adj_inc` from 22:30:00 → 01:30:00; `adj_sel`=00 from secd=59 → 00 with minte unchanged; no pulses. `set_en`=0 → next advance exactly DIV cycles later.
- Assert `rst` low mid-second with time 12:34:56 and `pc`=2 → outputs 00:00:00 immediately; after release, the first advance comes DIV cycles later.

Source files
------------

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: packed-BCD hh:mm:ss time-of-day counter.
// An internal prescaler divides cp by DIV to produce one advance per second.
// Supports a validated direct load, a set mode with per-field increment,
// and single-cycle pulses on second, hour and day rollover.
module bcd_time_counter #(
  parameter int DIV = 1000
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ld_h,
  input  logic [7:0] ld_m,
  input  logic [7:0] ld_s,
  input  logic       set_en,
  input  logic [1:0] adj_sel,
  input  logic       adj_inc,
  output logic [7:0] hours,
  output logic [7:0] minte,
  output logic [7:0] secd,
  output logic       sec_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_err
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  localparam logic [15:0] PC_MAX = 16'(DIV - 1);

  state_t      st;
  logic [15:0] pc;

  // BCD increment with wrap at lim; returns {wrapped, next_value}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)             return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)  return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic       ld_ok;
  logic       tick;
  logic [8:0] s_inc, m_inc, h_inc;

  // Once both digits are valid BCD, an unsigned compare against the BCD
  // limit is equivalent to a numeric range check.
  assign ld_ok = load && digits_ok(ld_h) && digits_ok(ld_m) && digits_ok(ld_s)
                 && (ld_h <= 8'h23) && (ld_m <= 8'h59) && (ld_s <= 8'h59);

  assign tick  = (st == RUN) && (pc == PC_MAX);
  assign s_inc = bcd_inc(secd,  8'h59);
  assign m_inc = bcd_inc(minte, 8'h59);
  assign h_inc = bcd_inc(hours, 8'h23);

  // State, prescaler, time fields and pulses; priority load > adjust > tick.
  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      st         <= RUN;
      pc         <= '0;
      hours      <= 8'h00;
      minte      <= 8'h00;
      secd       <= 8'h00;
      sec_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      sec_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      day_pulse  <= 1'b0;
      load_err   <= load && !ld_ok;
      st         <= set_en ? SET : RUN;

      if (ld_ok) begin
        hours <= ld_h;
        minte <= ld_m;
        secd  <= ld_s;
      end else if (st == SET && adj_inc) begin
        case (adj_sel)
          2'b00:   secd  <= s_inc[7:0];
          2'b01:   minte <= m_inc[7:0];
          2'b10:   hours <= h_inc[7:0];
          default: ;
        endcase
      end else if (tick) begin
        secd      <= s_inc[7:0];
        sec_pulse <= 1'b1;
        if (s_inc[8]) begin
          minte <= m_inc[7:0];
          if (m_inc[8]) begin
            hours      <= h_inc[7:0];
            hour_pulse <= 1'b1;
            day_pulse  <= h_inc[8];
          end
        end
      end

      // Held at 0 while in (or entering) SET, so the first second after
      // leaving SET is a full DIV cycles.
      if (ld_ok || st == SET || set_en || tick) pc <= '0;
      else                                      pc <= pc + 16'd1;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter (DIV=4): load table, directed corner
// sequences and randomized traffic against a seconds-of-day model.
module tb_bcd_time_counter;
  localparam int DIV = 4;

  logic       cp = 1'b0, rst = 1'b0, load = 1'b0, set_en = 1'b0, adj_inc = 1'b0;
  logic [1:0] adj_sel = 2'b11;
  logic [7:0] ld_h = 8'h00, ld_m = 8'h00, ld_s = 8'h00;
  logic [7:0] hours, minte, secd;
  logic       sec_pulse, hour_pulse, day_pulse, load_err;

  bcd_time_counter #(.DIV(DIV)) dut (
    .cp(cp), .rst(rst), .load(load), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
    .set_en(set_en), .adj_sel(adj_sel), .adj_inc(adj_inc),
    .hours(hours), .minte(minte), .secd(secd),
    .sec_pulse(sec_pulse), .hour_pulse(hour_pulse), .day_pulse(day_pulse),
    .load_err(load_err)
  );

  always #5 cp = ~cp;

  int checks = 0, errors = 0;
  int tod = 0, pcm = 0, npulse = 0;
  bit setm = 1'b0;
  bit e_sec = 1'b0, e_hour = 1'b0, e_day = 1'b0, e_err = 1'b0;

  typedef struct {
    logic [7:0] h, m, s;
    bit         err;
    logic [23:0] t;
  } ld_vec_t;

  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int dec(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic model_reset();
    tod = 0; pcm = 0; setm = 1'b0;
    e_sec = 1'b0; e_hour = 1'b0; e_day = 1'b0; e_err = 1'b0;
  endtask

  // Reference behaviour on one rising edge, kept as an integer second-of-day.
  task automatic step();
    int h, m, s;
    bit valid, tick;
    h = dec(ld_h); m = dec(ld_m); s = dec(ld_s);
    valid = ld_h[7:4] <= 9 && ld_h[3:0] <= 9 && ld_m[7:4] <= 9 && ld_m[3:0] <= 9 &&
            ld_s[7:4] <= 9 && ld_s[3:0] <= 9 && h < 24 && m < 60 && s < 60;
    tick  = !setm && pcm == DIV - 1;
    e_sec = 1'b0; e_hour = 1'b0; e_day = 1'b0;
    e_err = load && !valid;
    if (load && valid) begin
      tod = h * 3600 + m * 60 + s;
    end else if (setm && adj_inc && adj_sel != 2'b11) begin
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      case (adj_sel)
        2'b00:   s = (s + 1) % 60;
        2'b01:   m = (m + 1) % 60;
        default: h = (h + 1) % 24;
      endcase
      tod = h * 3600 + m * 60 + s;
    end else if (tick) begin
      tod    = (tod + 1) % 86400;
      e_sec  = 1'b1;
      e_hour = (tod % 3600) == 0;
      e_day  = tod == 0;
    end
    pcm  = ((load && valid) || setm || set_en) ? 0 : (pcm + 1) % DIV;
    setm = set_en;
  endtask

  task automatic cmp();
    chk("time", {8'h00, hours, minte, secd},
        {8'h00, bcd(tod / 3600), bcd((tod / 60) % 60), bcd(tod % 60)});
    chk("pulses", {28'h0, sec_pulse, hour_pulse, day_pulse, load_err},
        {28'h0, e_sec, e_hour, e_day, e_err});
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge cp);
      step();
      @(negedge cp);
      cmp();
      if (sec_pulse) npulse++;
    end
  endtask

  task automatic do_load(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    ld_h = h; ld_m = m; ld_s = s; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  ld_vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h23, 8'h59, 8'h59, 1'b0, 24'h235959};
    tbl[1] = '{8'h24, 8'h00, 8'h00, 1'b1, 24'h235959};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 24'h000000};
    tbl[3] = '{8'h09, 8'h5A, 8'h00, 1'b1, 24'h000000};
    tbl[4] = '{8'h19, 8'h59, 8'h59, 1'b0, 24'h195959};
    tbl[5] = '{8'h1A, 8'h00, 8'h00, 1'b1, 24'h195959};
    tbl[6] = '{8'h20, 8'h60, 8'h00, 1'b1, 24'h195959};
    tbl[7] = '{8'h00, 8'h00, 8'h60, 1'b1, 24'h195959};
    tbl[8] = '{8'h09, 8'h09, 8'h09, 1'b0, 24'h090909};

    // Reset state
    model_reset();
    #12;
    cmp();
    @(negedge cp);
    rst = 1'b1;

    // Free-run: one advance per DIV cycles
    npulse = 0;
    cyc(12);
    chk("run12 secd", {24'h0, secd}, 32'h03);
    chk("run12 pulses", 32'(npulse), 32'd3);

    // Minute carry without hour pulse
    do_load(8'h00, 8'h00, 8'h58);
    cyc(8);
    chk("min carry", {8'h0, hours, minte, secd}, 32'h000100);

    // Day rollover: all three pulses in one cycle
    do_load(8'h23, 8'h59, 8'h59);
    cyc(4);
    chk("day roll", {5'h0, hours, minte, secd, sec_pulse, hour_pulse, day_pulse},
        {5'h0, 24'h000000, 3'b111});

    // Rejected loads while running
    do_load(8'h24, 8'h00, 8'h00);
    chk("rej 24h err", {31'h0, load_err}, 32'h1);
    do_load(8'h12, 8'h5A, 8'h00);
    chk("rej 5A err", {31'h0, load_err}, 32'h1);
    cyc(9);

    // Load table applied in set mode (no ticks interfere)
    set_en = 1'b1;
    cyc(1);
    for (int i = 0; i < 9; i++) begin
      do_load(tbl[i].h, tbl[i].m, tbl[i].s);
      chk("tbl err", {31'h0, load_err}, {31'h0, tbl[i].err});
      chk("tbl time", {8'h0, hours, minte, secd}, {8'h0, tbl[i].t});
    end

    // Adjust hours with wrap, then seconds without carry
    do_load(8'h22, 8'h30, 8'h00);
    adj_sel = 2'b10; adj_inc = 1'b1;
    cyc(3);
    adj_inc = 1'b0;
    chk("adj hours", {8'h0, hours, minte, secd}, 32'h013000);
    do_load(8'h01, 8'h30, 8'h59);
    adj_sel = 2'b00; adj_inc = 1'b1;
    cyc(1);
    adj_inc = 1'b0;
    chk("adj secs", {5'h0, hours, minte, secd, sec_pulse, hour_pulse, day_pulse},
        {5'h0, 24'h013000, 3'b000});
    adj_sel = 2'b11; adj_inc = 1'b1;
    cyc(2);
    adj_inc = 1'b0;
    set_en = 1'b0;
    cyc(1);
    cyc(DIV - 1);
    chk("set exit hold", {24'h0, secd}, 32'h00);
    cyc(1);
    chk("set exit adv", {24'h0, secd}, 32'h01);

    // Asynchronous reset mid-second
    do_load(8'h12, 8'h34, 8'h56);
    cyc(2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async rst", {8'h0, hours, minte, secd}, 32'h0);
    cmp();
    @(negedge cp);
    rst = 1'b1;
    cyc(DIV - 1);
    chk("post rst hold", {24'h0, secd}, 32'h00);
    cyc(1);
    chk("post rst adv", {24'h0, secd}, 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom % 30) == 0;
      case ($urandom % 4)
        0: begin ld_h = $urandom; ld_m = $urandom; ld_s = $urandom; end
        1: begin ld_h = 8'h23; ld_m = 8'h59; ld_s = bcd(56 + int'($urandom % 4)); end
        2: begin ld_h = bcd(int'($urandom % 24)); ld_m = 8'h59; ld_s = 8'h58; end
        default: begin
          ld_h = bcd(int'($urandom % 24)); ld_m = bcd(int'($urandom % 60));
          ld_s = bcd(int'($urandom % 60));
        end
      endcase
      if (($urandom % 60) == 0) set_en = ~set_en;
      adj_sel = 2'($urandom);
      adj_inc = ($urandom % 3) == 0;
      cyc(1);
    end
    load = 1'b0; adj_inc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
